// File: rtl/disp_pkg.sv
// disp_pkg: shared types and helpers for the 7-segment digit scanner.
//   state_t  : scanner slot phase (guard interval / digit shown)
//   NIBBLE_W : width of one hex digit
//   cnt_w()  : slot counter width for a given slot length
package disp_pkg;

  typedef enum logic {
    S_GUARD = 1'b0,
    S_SHOW  = 1'b1
  } state_t;

  localparam int NIBBLE_W = 4;

  // Width of a counter that runs 0..div-1.
  function automatic int cnt_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/disp_scan.sv
// disp_scan: time-multiplexed scanner for common-anode 7-segment displays.
// Feeds the hex decoder's nibble input and drives active-low digit enables.
// Every digit slot is DIV cycles long; the first GUARD cycles of each slot
// keep all anodes off so the previous digit's segments cannot ghost.
// Display data is double-buffered and only switches at a frame boundary.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   data_i      : DIGITS nibbles, digit 0 in the low nibble (rightmost)
//   blank_i     : per-digit dark request (1 = dark)
//   load_i      : single-cycle strobe capturing data_i / blank_i
//   nibble_o    : current digit's nibble, to the hex decoder
//   an_o        : active-low anodes, one-hot-low or all ones
//   frame_o     : one-cycle pulse when the digit index returns to 0
//   pending_o   : shadow holds a word not yet on display
module disp_scan
  import disp_pkg::*;
#(
  parameter int DIGITS = 4,     // 2..8
  parameter int DIV    = 50000, // cycles per digit slot, guard included
  parameter int GUARD  = 500    // 1 <= GUARD < DIV
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NIBBLE_W*DIGITS-1:0]   data_i,
  input  logic [DIGITS-1:0]            blank_i,
  input  logic                         load_i,
  output logic [NIBBLE_W-1:0]          nibble_o,
  output logic [DIGITS-1:0]            an_o,
  output logic                         frame_o,
  output logic                         pending_o
);

  localparam int CW = cnt_w(DIV);
  localparam int DW = $clog2(DIGITS);

  typedef logic [DIGITS-1:0][NIBBLE_W-1:0] word_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [DW-1:0]   dig, dig_n;
  word_t           act_d, act_d_n, shd_d, shd_d_n;
  logic [DIGITS-1:0] act_b, act_b_n, shd_b, shd_b_n;
  logic            pend_n, frame_n;
  logic [NIBBLE_W-1:0] nib_n;
  logic [DIGITS-1:0]   an_n;
  logic            slot_end, wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_GUARD;
      cnt       <= '0;
      dig       <= '0;
      act_d     <= '0;
      act_b     <= '0;
      shd_d     <= '0;
      shd_b     <= '0;
      pending_o <= 1'b0;
      frame_o   <= 1'b0;
      nibble_o  <= '0;
      an_o      <= '1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      dig       <= dig_n;
      act_d     <= act_d_n;
      act_b     <= act_b_n;
      shd_d     <= shd_d_n;
      shd_b     <= shd_b_n;
      pending_o <= pend_n;
      frame_o   <= frame_n;
      nibble_o  <= nib_n;
      an_o      <= an_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    dig_n   = dig;
    act_d_n = act_d;
    act_b_n = act_b;
    shd_d_n = shd_d;
    shd_b_n = shd_b;
    pend_n  = pending_o;

    slot_end = (cnt == CW'(DIV - 1));
    // The frame boundary is the last cycle of the last digit's slot:
    // the index wraps to 0 at the end of it.
    wrap     = slot_end && (dig == DW'(DIGITS - 1));
    frame_n  = wrap;

    if (slot_end) begin
      cnt_n   = '0;
      state_n = S_GUARD;
      dig_n   = wrap ? '0 : dig + 1'b1;
    end else if (state == S_GUARD && cnt == CW'(GUARD - 1)) begin
      state_n = S_SHOW;
    end

    if (wrap) begin
      // A load landing on the boundary goes straight to the active copy
      // and supersedes anything waiting in the shadow.
      if (load_i) begin
        act_d_n = data_i;
        act_b_n = blank_i;
        pend_n  = 1'b0;
      end else if (pending_o) begin
        act_d_n = shd_d;
        act_b_n = shd_b;
        pend_n  = 1'b0;
      end
    end else if (load_i) begin
      shd_d_n = data_i;
      shd_b_n = blank_i;
      pend_n  = 1'b1;
    end

    // Registered outputs are derived from next-state values so the nibble
    // is already valid when the new slot's guard interval begins.
    nib_n = act_d_n[dig_n];
    an_n  = '1;
    if (state_n == S_SHOW)
      an_n[dig_n] = act_b_n[dig_n]; // pulled low only when not blanked
  end

endmodule

// File: tb/tb_disp_scan.sv
// tb_disp_scan: randomized + directed bench for disp_scan (4 digits, DIV=8,
// GUARD=2). Expected outputs come from a frame-position model: the cycle
// index since reset release decides digit, slot position and frame pulse.
module tb_disp_scan;

  localparam int DIGITS = 4;
  localparam int DIV    = 8;
  localparam int GUARD  = 2;
  localparam int FRAME  = DIGITS * DIV;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [4*DIGITS-1:0]  data_i = '0;
  logic [DIGITS-1:0]    blank_i = '0;
  logic                 load_i = 1'b0;
  logic [3:0]           nibble_o;
  logic [DIGITS-1:0]    an_o;
  logic                 frame_o;
  logic                 pending_o;

  disp_scan #(.DIGITS(DIGITS), .DIV(DIV), .GUARD(GUARD)) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .blank_i(blank_i),
    .load_i(load_i), .nibble_o(nibble_o), .an_o(an_o),
    .frame_o(frame_o), .pending_o(pending_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // model state
  int               n;
  logic [3:0]       m_act [DIGITS];
  logic [3:0]       m_shd [DIGITS];
  logic             m_actb [DIGITS];
  logic             m_shdb [DIGITS];
  logic             m_pend;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h", tag, n, got, exp);
  endtask

  task automatic model_reset();
    n = 0;
    m_pend = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      m_act[k] = '0; m_shd[k] = '0; m_actb[k] = 1'b0; m_shdb[k] = 1'b0;
    end
  endtask

  task automatic check_cycle();
    int dig, pos;
    logic [DIGITS-1:0] e_an;
    dig = (n / DIV) % DIGITS;
    pos = n % DIV;
    e_an = '1;
    if (pos >= GUARD && !m_actb[dig]) e_an[dig] = 1'b0;
    chk("an", 32'(an_o), 32'(e_an));
    chk("nibble", 32'(nibble_o), 32'(m_act[dig]));
    chk("frame", 32'(frame_o), 32'((n != 0 && n % FRAME == 0) ? 1 : 0));
    chk("pending", 32'(pending_o), 32'(m_pend));
  endtask

  // one cycle: check at negedge, drive inputs, advance model across posedge
  task automatic run_cycle(input logic ld, input logic [15:0] d, input logic [3:0] b);
    check_cycle();
    load_i = ld; data_i = d; blank_i = b;
    @(posedge clk);
    if (n % FRAME == FRAME - 1) begin
      if (ld) begin
        for (int k = 0; k < DIGITS; k++) begin m_act[k] = d[4*k +: 4]; m_actb[k] = b[k]; end
      end else if (m_pend) begin
        for (int k = 0; k < DIGITS; k++) begin m_act[k] = m_shd[k]; m_actb[k] = m_shdb[k]; end
      end
      m_pend = 1'b0;
    end else if (ld) begin
      for (int k = 0; k < DIGITS; k++) begin m_shd[k] = d[4*k +: 4]; m_shdb[k] = b[k]; end
      m_pend = 1'b1;
    end
    n++;
    @(negedge clk);
    load_i = 1'b0;
  endtask

  task automatic idle_until(input int target);
    while (n < target) run_cycle(1'b0, 16'h0, 4'h0);
  endtask

  task automatic rand_cycles(input int cnt);
    logic ld;
    logic [15:0] d;
    logic [3:0] b;
    for (int i = 0; i < cnt; i++) begin
      ld = ($urandom_range(0, 7) == 0) ||
           ((n % FRAME == FRAME - 1) && $urandom_range(0, 1) == 1);
      d  = 16'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      run_cycle(ld, d, b);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    // reset values while held
    chk("rst_an", 32'(an_o), 32'hF);
    chk("rst_nib", 32'(nibble_o), 32'h0);
    rst_n = 1'b1;

    // frame 0: idle, then load 1A2F at cycle 5
    idle_until(5);
    run_cycle(1'b1, 16'h1A2F, 4'h0);
    idle_until(FRAME);
    // frame 1 shows 1A2F; two loads, last wins
    idle_until(FRAME + 8);
    run_cycle(1'b1, 16'h1111, 4'h0);
    idle_until(FRAME + 18);
    run_cycle(1'b1, 16'h2222, 4'h0);
    idle_until(3 * FRAME - 1);
    // bypass load on the boundary cycle
    run_cycle(1'b1, 16'h3333, 4'h0);
    idle_until(3 * FRAME + 4);
    // blank digit 2
    run_cycle(1'b1, 16'h4567, 4'b0100);
    idle_until(5 * FRAME + 2);

    rand_cycles(300);

    // asynchronous reset mid-SHOW of digit 2
    while (n % FRAME != 2 * DIV + 4) run_cycle(1'b0, 16'h0, 4'h0);
    check_cycle();
    rst_n = 1'b0;
    #1;
    chk("async_an", 32'(an_o), 32'hF);
    chk("async_nib", 32'(nibble_o), 32'h0);
    chk("async_frame", 32'(frame_o), 32'h0);
    chk("async_pend", 32'(pending_o), 32'h0);
    @(posedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    idle_until(FRAME + 4);
    rand_cycles(150);
    check_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
